// File: rtl/adc_capture_pkg.sv
// Shared definitions for the multi-channel ADC capture block: channel tag
// width, the channel-count ceiling, the sequencer advance reasons and a
// ceiling-log2 helper used to size counters from parameters.
package adc_capture_pkg;

  // Width of the ADC channel request / sample tag.
  localparam int CH_W   = 4;

  // Largest channel count a CH_W-bit tag can address.
  localparam int MAX_CH = 16;

  // Why the sequencer moves on from the current channel this cycle.
  typedef enum logic [1:0] {
    ADV_NONE    = 2'd0,
    ADV_MATCH   = 2'd1,
    ADV_TIMEOUT = 2'd2
  } adv_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adc_slot_avg.sv
// One capture slot: accumulates 2^AVG_LOG2 samples, publishes their
// truncated mean, and drives a PWM LED from a compare register that only
// reloads at the end of a PWM period so the duty cycle never glitches.
module adc_slot_avg #(
  parameter int SAMPLE_W = 10,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                hold,
  input  logic                pwm_wrap,
  input  logic [SAMPLE_W-1:0] pwm_cnt,
  output logic [SAMPLE_W-1:0] value,
  output logic                done,
  output logic                led
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  // A zero-width count is not legal; with AVG_LOG2 = 0 the single bit stays 0.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] compare;
  logic                last;
  logic [ACC_W-1:0]    sum;

  // Detect the final sample of an averaging window and form the running sum.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    last = 1'b0;
    sum  = '0;
    last = (cnt == CNT_W'((1 << AVG_LOG2) - 1));
    sum  = acc + ACC_W'(sample);
    done = accept && last && !hold;
  end

  // Accumulator, published value, PWM compare latch and registered LED.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      value   <= '0;
      compare <= '0;
      led     <= 1'b0;
    end else begin
      led <= (pwm_cnt < compare);
      if (pwm_wrap && !hold) compare <= value;
      if (accept) begin
        if (last) begin
          // A window completing under hold is dropped, but still restarts.
          acc <= '0;
          cnt <= '0;
          if (!hold) value <= SAMPLE_W'(sum >> AVG_LOG2);
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_multi_capture.sv
// Multi-channel ADC capture: requests channels round-robin, routes tagged
// samples into per-channel averaging slots, flags channels that time out,
// and drives one PWM LED per slot from a shared free-running counter.
// Optional feature macro: ADC_CAPTURE_HOLD_EN adds a 'hold' input that
// freezes published values, value_valid and PWM compare registers.
module adc_multi_capture
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int SAMPLE_W = 10,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef ADC_CAPTURE_HOLD_EN
  input  logic                         hold,
`endif
  output logic [CH_W-1:0]              channel,
  input  logic                         new_sample,
  input  logic [SAMPLE_W-1:0]          sample,
  input  logic [CH_W-1:0]              sample_channel,
  output logic [NUM_CH*SAMPLE_W-1:0]   value,
  output logic                         value_valid,
  output logic [CH_W-1:0]              value_ch,
  output logic [NUM_CH-1:0]            stale,
  output logic [NUM_CH-1:0]            led
);

  localparam int TO_W = clog2(TIMEOUT);

  logic                hold_i;
  logic [TO_W-1:0]     to_cnt;
  logic [SAMPLE_W-1:0] pwm_cnt;
  logic                pwm_wrap;
  logic                accept;
  logic                match;
  logic [CH_W-1:0]     channel_inc;
  adv_e                adv;
  logic [NUM_CH-1:0]   slot_accept;
  logic [NUM_CH-1:0]   slot_done;
  logic [NUM_CH-1:0]   stale_next;

`ifdef ADC_CAPTURE_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  // Accept decode, sequencer advance reason and next stale flags.
  always_comb begin
    // One extra bit so NUM_CH = 16 still compares correctly against the tag.
    accept      = new_sample && ({1'b0, sample_channel} < (CH_W + 1)'(NUM_CH));
    match       = accept && (sample_channel == channel);
    channel_inc = (channel == CH_W'(NUM_CH - 1)) ? '0 : channel + 1'b1;
    pwm_wrap    = &pwm_cnt;
    adv         = ADV_NONE;
    if (match) begin
      adv = ADV_MATCH;
    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
      adv = ADV_TIMEOUT;
    end
    stale_next = stale;
    for (int i = 0; i < NUM_CH; i++) begin
      // A fresh sample always wins over a timeout on the same slot.
      if (slot_accept[i]) begin
        stale_next[i] = 1'b0;
      end else if ((adv == ADV_TIMEOUT) && (channel == CH_W'(i))) begin
        stale_next[i] = 1'b1;
      end
    end
  end

  // Sequencer, timeout counter, PWM counter, stale flags and update strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      channel     <= '0;
      to_cnt      <= '0;
      pwm_cnt     <= '0;
      stale       <= '0;
      value_valid <= 1'b0;
      value_ch    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (adv != ADV_NONE) begin
        channel <= channel_inc;
        to_cnt  <= '0;
      end else begin
        to_cnt  <= to_cnt + 1'b1;
      end
      stale       <= stale_next;
      value_valid <= |slot_done;
      if (|slot_done) value_ch <= sample_channel;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    assign slot_accept[i] = accept && (sample_channel == CH_W'(i));

    adc_slot_avg #(
      .SAMPLE_W (SAMPLE_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .accept   (slot_accept[i]),
      .sample   (sample),
      .hold     (hold_i),
      .pwm_wrap (pwm_wrap),
      .pwm_cnt  (pwm_cnt),
      .value    (value[i*SAMPLE_W +: SAMPLE_W]),
      .done     (slot_done[i]),
      .led      (led[i])
    );
  end

endmodule

// File: tb/tb_adc_multi_capture.sv
// Self-checking bench for adc_multi_capture: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural model of channel scanning, averaging, staleness and PWM.
module tb_adc_multi_capture;

  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 10;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 16;
  localparam int AVG_N    = 1 << AVG_LOG2;
  localparam int PWM_MAX  = (1 << SAMPLE_W) - 1;

  logic                       clk;
  logic                       rst;
  logic                       hold;
  logic [3:0]                 channel;
  logic                       new_sample;
  logic [SAMPLE_W-1:0]        sample;
  logic [3:0]                 sample_channel;
  logic [NUM_CH*SAMPLE_W-1:0] value;
  logic                       value_valid;
  logic [3:0]                 value_ch;
  logic [NUM_CH-1:0]          stale;
  logic [NUM_CH-1:0]          led;

  int n_cmp = 0;
  int n_bad = 0;

  adc_multi_capture #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef ADC_CAPTURE_HOLD_EN
    .hold           (hold),
`endif
    .channel        (channel),
    .new_sample     (new_sample),
    .sample         (sample),
    .sample_channel (sample_channel),
    .value          (value),
    .value_valid    (value_valid),
    .value_ch       (value_ch),
    .stale          (stale),
    .led            (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_channel = 0;
  int m_wait    = 0;
  int m_pwm     = 0;
  int m_sum  [NUM_CH];
  int m_n    [NUM_CH];
  int m_val  [NUM_CH];
  int m_cmp  [NUM_CH];
  bit m_led  [NUM_CH];
  bit m_stale[NUM_CH];
  bit m_valid = 0;
  int m_vch   = 0;
  bit started = 0;

  always @(posedge clk) begin
    int t;
    bit hit;
    if (rst) begin
      m_channel = 0; m_wait = 0; m_pwm = 0; m_valid = 0; m_vch = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_sum[i] = 0; m_n[i] = 0; m_val[i] = 0; m_cmp[i] = 0;
        m_led[i] = 0; m_stale[i] = 0;
      end
    end else begin
      // LED reflects the counter/compare seen before this edge.
      for (int i = 0; i < NUM_CH; i++) m_led[i] = (m_pwm < m_cmp[i]);
      if (m_pwm == PWM_MAX && !hold)
        for (int i = 0; i < NUM_CH; i++) m_cmp[i] = m_val[i];
      m_valid = 0;
      hit = 0;
      if (new_sample && sample_channel < NUM_CH) begin
        t = int'(sample_channel);
        m_stale[t] = 0;
        m_sum[t] += int'(sample);
        m_n[t]++;
        if (m_n[t] == AVG_N) begin
          if (!hold) begin
            m_val[t] = m_sum[t] / AVG_N;
            m_valid  = 1;
            m_vch    = t;
          end
          m_sum[t] = 0;
          m_n[t]   = 0;
        end
        hit = (t == m_channel);
      end
      if (hit) begin
        m_channel = (m_channel + 1) % NUM_CH;
        m_wait    = 0;
      end else if (m_wait == TIMEOUT - 1) begin
        m_stale[m_channel] = 1;
        m_channel = (m_channel + 1) % NUM_CH;
        m_wait    = 0;
      end else begin
        m_wait++;
      end
      m_pwm = (m_pwm + 1) % (PWM_MAX + 1);
    end
    started = 1;
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NUM_CH*SAMPLE_W-1:0] ev;
    logic [NUM_CH-1:0]          es;
    logic [NUM_CH-1:0]          el;
    int tmp;
    if (started) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tmp = m_val[i];
        ev[i*SAMPLE_W +: SAMPLE_W] = tmp[SAMPLE_W-1:0];
        es[i] = m_stale[i];
        el[i] = m_led[i];
      end
      check("model_channel", channel, m_channel);
      check("model_value", value, ev);
      check("model_value_valid", value_valid, m_valid);
      if (m_valid) check("model_value_ch", value_ch, m_vch);
      check("model_stale", stale, es);
      check("model_led", led, el);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit ns, input int tag, input int smp);
    new_sample     = ns;
    sample_channel = tag[3:0];
    sample         = smp[SAMPLE_W-1:0];
    @(posedge clk);
    #1;
    new_sample = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    new_sample = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int cnt0, cnt1, rate, tag, smp, r;
    rst = 1'b1; hold = 1'b0; new_sample = 1'b0; sample = '0; sample_channel = '0;
    do_reset();

    // Reset state.
    check("reset_channel", channel, 0);
    check("reset_value", value, 0);
    check("reset_stale", stale, 0);
    check("reset_led", led, 0);
    check("reset_valid", value_valid, 0);

    // Matching scan across all channels, one sample every 10 cycles.
    for (int k = 0; k < NUM_CH; k++) begin
      cyc(1'b1, k, $urandom_range(0, PWM_MAX));
      check("scan_channel", channel, (k + 1) % NUM_CH);
      idle(9);
    end
    check("scan_value_zero", value, 0);
    check("scan_stale_zero", stale, 0);
    check("scan_led_zero", led, 0);

    // Averaging slot 3: 100..103 -> 101.
    do_reset();
    cyc(1'b1, 3, 100); cyc(1'b1, 3, 101); cyc(1'b1, 3, 102); cyc(1'b1, 3, 103);
    check("avg_value3", value[3*SAMPLE_W +: SAMPLE_W], 101);
    check("avg_valid", value_valid, 1);
    check("avg_value_ch", value_ch, 3);
    idle(1);
    check("avg_valid_once", value_valid, 0);

    // Timeout: channels 0..5 time out after 16 cycles each.
    do_reset();
    idle(100);
    check("to_channel", channel, 6);
    check("to_stale", stale, 8'h3F);
    cyc(1'b1, 5, 77);
    check("to_stale_clear", stale, 8'h1F);
    check("to_channel_kept", channel, 6);
    cyc(1'b1, 12, 500);
    check("oor_stale", stale, 8'h1F);
    check("oor_channel", channel, 6);
    cyc(1'b1, 2, 300);
    check("mismatch_channel", channel, 6);

    // PWM duty: slot 0 = 256, slot 1 = 0.
    do_reset();
    repeat (AVG_N) cyc(1'b1, 0, 256);
    check("pwm_value0", value[SAMPLE_W-1:0], 256);
    idle(1100);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k <= PWM_MAX; k++) begin
      idle(1);
      cnt0 += int'(led[0]);
      cnt1 += int'(led[1]);
    end
    check("pwm_high_256", cnt0, 256);
    check("pwm_zero_never", cnt1, 0);

`ifdef ADC_CAPTURE_HOLD_EN
    // Hold discards a completed average; the next window publishes normally.
    do_reset();
    hold = 1'b1;
    repeat (AVG_N) cyc(1'b1, 4, 200);
    check("hold_value_frozen", value[4*SAMPLE_W +: SAMPLE_W], 0);
    check("hold_no_valid", value_valid, 0);
    hold = 1'b0;
    cyc(1'b1, 4, 40); cyc(1'b1, 4, 41); cyc(1'b1, 4, 42); cyc(1'b1, 4, 43);
    check("hold_after_value", value[4*SAMPLE_W +: SAMPLE_W], 41);
    check("hold_after_valid", value_valid, 1);
`endif

    // Randomized traffic with varying density, occasional resets.
    do_reset();
    rate = 40;
    for (int n = 0; n < 6000; n++) begin
      if (n % 500 == 0) begin
        r = $urandom_range(0, 2);
        rate = (r == 0) ? 5 : (r == 1) ? 40 : 85;
      end
      if ($urandom_range(0, 799) == 0) do_reset();
`ifdef ADC_CAPTURE_HOLD_EN
      if ($urandom_range(0, 29) == 0) hold = ~hold;
`endif
      tag = ($urandom_range(0, 1) == 1) ? m_channel : $urandom_range(0, 15);
      r   = $urandom_range(0, 9);
      smp = (r == 0) ? 0 : (r == 1) ? PWM_MAX : $urandom_range(0, PWM_MAX);
      cyc($urandom_range(0, 99) < rate, tag, smp);
    end
    hold = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_multi_capture.md
Name: adc_multi_capture

Overview:
Multi-channel successor to the single-channel A0 capture block. It sequences the ADC through NUM_CH channels round-robin and accepts tagged samples into per-channel slots. Each slot is averaged over 2^AVG_LOG2 samples, and each averaged value drives a glitch-free PWM LED output. It sits between the ADC front end (channel / new_sample / sample / sample_channel) and the board LEDs, and it exports the averaged values for downstream logic.

Parameters:
NUM_CH, 8, number of channels scanned (1..16); slot i maps to ADC channel i.
SAMPLE_W, 10, ADC sample width; also the PWM counter width.
AVG_LOG2, 2, log2 of samples averaged per output update (0 = passthrough, max 6).
TIMEOUT, 1024, cycles to wait for a matching sample before forcing a channel advance.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
channel  out  4  ADC channel currently requested
new_sample  in  1  sample/sample_channel valid this cycle
sample  in  SAMPLE_W  ADC sample
sample_channel  in  4  channel tag of sample
value  out  NUM_CH*SAMPLE_W  averaged values, slot i at [i*SAMPLE_W +: SAMPLE_W]
value_valid  out  1  one-cycle pulse: a slot's value was just updated
value_ch  out  4  slot updated; meaningful only while value_valid is high
stale  out  NUM_CH  slot i timed out with no fresh sample since
led  out  NUM_CH  PWM of value slot i

Behaviour:
- Reset values: channel=0, value=0, value_valid=0, value_ch=0, stale=0, led=0. All accumulators, sample counts, the timeout counter and the PWM counter are cleared to 0.
- Reset asserted mid-operation discards partial averages. No sample is accepted in the reset cycle.
- Accept: a sample is accepted when new_sample is high and sample_channel < NUM_CH. Samples tagged sample_channel >= NUM_CH are ignored.
- Every accepted sample goes into slot sample_channel, whether or not it matches channel.
- Sequencer: when an accepted sample has sample_channel == channel, channel advances to (channel+1) mod NUM_CH on the next edge. The timeout counter resets to 0 on every channel change.
- Timeout: the counter increments each cycle in which no matching sample arrives. When it reaches TIMEOUT-1, channel advances, stale[channel] is set, and the counter resets.
- stale[i] clears on the edge at which slot i accepts a sample. If a sample is accepted in the same cycle as a timeout, the sample wins: stale stays clear and the channel advances once.
- Averaging, per slot: the accumulator is SAMPLE_W+AVG_LOG2 bits, unsigned, and the count is AVG_LOG2 bits.
- On an accepted sample that is not the last: acc += sample and count += 1.
- On the 2^AVG_LOG2-th sample: value slot = (acc + sample) >> AVG_LOG2 (truncating), acc=0, count=0, value_valid=1 and value_ch=slot in the following cycle.
- Latency: the sample is accepted in cycle N; value and value_valid are visible in cycle N+1.
- With AVG_LOG2=0, every accepted sample updates value directly.
- PWM: one shared free-running SAMPLE_W-bit counter, wrapping 2^SAMPLE_W-1 -> 0.
- Per slot, the compare register latches value only in the cycle the counter equals all-ones, so a new value takes effect at the start of the next period.
- led[i] = (counter < compare[i]), registered. compare=0 gives LED constantly low; compare=all-ones gives LED low for 1 cycle per period.

Optional Feature:
ADC_CAPTURE_HOLD_EN:
- When defined: adds input port hold (1 bit).
- While hold is high, the value slots, value_valid and the PWM compare registers are frozen.
- The sequencer, timeout logic and stale flags keep running.
- Accumulators keep averaging. A completed average arriving during hold is discarded: acc and count are cleared and value is left unchanged.
- When not defined: the port is absent and behaviour is as above.

Decomposition:
- Package adc_capture_pkg holds:
  - localparam CH_W=4 (ADC channel tag width);
  - the maximum NUM_CH (16);
  - a function clog2 for sizing the timeout counter.
- One natural sub-module, adc_slot_avg: one accumulator, count, value register and compare latch. It is instantiated NUM_CH times via generate.
- The sequencer, timeout logic and shared PWM counter live in the top level.

Test Plan:
- Reset scan: rst for 2 cycles, then feed NUM_CH=8 matching samples, one every 10 cycles -> channel steps 0,1,...,7,0; value, led and stale all stay 0 until the first average completes.
- Averaging, AVG_LOG2=2: slot 3 receives 100,101,102,103 -> value[3]=101 (truncated 406/4) in the cycle after the 4th sample; value_valid pulses exactly once with value_ch=3.
- Timeout, TIMEOUT=16: no new_sample on channel 5 -> channel advances to 6 after 16 cycles and stale[5]=1. A later sample tagged 5 clears stale[5]; channel is unaffected because it no longer matches.
- Out-of-range and mismatched tags: sample_channel=12 with NUM_CH=8 -> ignored, no state change. sample_channel=2 while channel=4 -> slot 2 accumulates; channel stays 4.
- PWM, SAMPLE_W=10: slot 0 value=256 -> led[0] high for exactly 256 of 1024 cycles starting at the next period. Changing value mid-period does not alter the current period. value=0 -> led[0] never high.
- Hold (ADC_CAPTURE_HOLD_EN): hold=1 during a completed average -> value unchanged, no value_valid pulse, acc cleared. After hold=0, the next 4 samples update value normally.
